// File: rtl/div_pkg.sv
// Shared definitions for the divider issue/control stage: op encodings,
// FSM state type and timing constants.
package div_pkg;

   localparam logic [1:0] DIV_W  = 2'b00;
   localparam logic [1:0] MOD_W  = 2'b01;
   localparam logic [1:0] DIV_WU = 2'b10;
   localparam logic [1:0] MOD_WU = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_e;

   // Cycles from the first core_div-high cycle to the core_complete pulse.
   localparam int CORE_LATENCY    = 34;
   localparam int WDOG_CYCLES_DEF = 40;

endpackage

// File: rtl/div_issue_ctrl.sv
// Issue/control stage in front of the iterative radix-2 divider core.
// Optional macro DIV_ZERO_FAST_EN: divide-by-zero answered locally in one cycle.
module div_issue_ctrl
   import div_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
   input  logic            div_clk,
   input  logic            reset,
   // Handshakes: a transfer happens on a clock edge where valid && ready are
   // both high; valid never depends on ready in the same cycle.
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      in_op,
   input  logic [XLEN-1:0] in_src1,
   input  logic [XLEN-1:0] in_src2,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic            wdog_err,
   output logic            core_div,
   output logic            core_signed,
   output logic [XLEN-1:0] core_x,
   output logic [XLEN-1:0] core_y,
   input  logic [XLEN-1:0] core_s,
   input  logic [XLEN-1:0] core_r,
   input  logic            core_complete,
   output div_state_e      dbg_state
);

   localparam int CW = $clog2(WDOG_CYCLES + 1);

   div_state_e      state_q, state_d;
   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;
   logic [XLEN-1:0] out_result_q, out_result_d;
   logic            core_div_q, core_div_d;
   logic            core_signed_q, core_signed_d;
   logic [XLEN-1:0] core_x_q, core_x_d;
   logic [XLEN-1:0] core_y_q, core_y_d;
   logic            sel_rem_q, sel_rem_d;
   logic            wdog_err_q, wdog_err_d;
   logic [CW-1:0]   busy_cnt_q, busy_cnt_d;

   always_comb begin
      state_d       = state_q;
      out_result_d  = out_result_q;
      core_signed_d = core_signed_q;
      core_x_d      = core_x_q;
      core_y_d      = core_y_q;
      sel_rem_d     = sel_rem_q;
      wdog_err_d    = wdog_err_q;
      busy_cnt_d    = busy_cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid && !flush) begin
               core_x_d      = in_src1;
               core_y_d      = in_src2;
               core_signed_d = ~in_op[1];
               sel_rem_d     = in_op[0];
               busy_cnt_d    = '0;
               state_d       = BUSY;
`ifdef DIV_ZERO_FAST_EN
               if (in_src2 == '0) begin
                  state_d      = DONE;
                  out_result_d = in_op[0] ? in_src1 : '1;
               end
`endif
            end
         end
         BUSY: begin
            busy_cnt_d = CW'(busy_cnt_q + 1'b1);
            if (core_complete) begin
               // Core outputs are only meaningful during the completion pulse.
               if (!flush) out_result_d = sel_rem_q ? core_r : core_s;
               state_d = DONE;
            end else if (busy_cnt_d == CW'(WDOG_CYCLES)) begin
               wdog_err_d = 1'b1;
               state_d    = IDLE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
      // Outputs are registered copies of the next state's decode.
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      core_div_d  = (state_d == BUSY);
   end

   always_ff @(posedge div_clk) begin
      if (reset) begin
         state_q       <= IDLE;
         in_ready_q    <= 1'b1;
         out_valid_q   <= 1'b0;
         out_result_q  <= '0;
         core_div_q    <= 1'b0;
         core_signed_q <= 1'b0;
         core_x_q      <= '0;
         core_y_q      <= '0;
         sel_rem_q     <= 1'b0;
         wdog_err_q    <= 1'b0;
         busy_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         in_ready_q    <= in_ready_d;
         out_valid_q   <= out_valid_d;
         out_result_q  <= out_result_d;
         core_div_q    <= core_div_d;
         core_signed_q <= core_signed_d;
         core_x_q      <= core_x_d;
         core_y_q      <= core_y_d;
         sel_rem_q     <= sel_rem_d;
         wdog_err_q    <= wdog_err_d;
         busy_cnt_q    <= busy_cnt_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_result  = out_result_q;
   assign core_div    = core_div_q;
   assign core_signed = core_signed_q;
   assign core_x      = core_x_q;
   assign core_y      = core_y_q;
   assign wdog_err    = wdog_err_q;
   assign dbg_state   = state_q;

endmodule
